data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data port, with a word-addressed RAM behind a cs/we request and ready/err handshake.
- Accepts one read or write at a time, inserts a programmable number of wait states, then returns read data or write completion with a one-cycle ready pulse.
- Allows the CPU datapath to be exercised against multi-cycle memory.
- Drives the stall input of the hazard logic through ready_o.

Parameters:
- SIZE, 32, number of 32-bit words in the array (power of two, 2..1024).
- LATENCY, 2, wait-state cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- cs  input  1  request valid; held by the initiator until ready_o.
- we  input  1  1 = write, 0 = read; sampled with cs.
- addr_i  input  32  byte address; word index = addr_i[31:2].
- data_i  input  32  write data; sampled with cs.
- data_o  output  32  read data; valid only while ready_o = 1.
- ready_o  output  1  one-cycle response pulse.
- err_o  output  1  error flag; valid only while ready_o = 1.
- busy_o  output  1  high from request acceptance until the ready cycle, inclusive.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state goes to IDLE; wait counter = 0.
  - data_o = 0, ready_o = 0, err_o = 0, busy_o = 0.
  - Latched request registers are cleared.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If cs = 1, latch addr_i, data_i and we; set busy_o = 1; load counter with LATENCY.
  - If LATENCY = 0, go to RESP; otherwise go to WAIT.
  - If cs = 0, stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is RESP. Total cycles from acceptance edge to ready_o high = LATENCY + 1.
- RESP:
  - ready_o = 1 for exactly one cycle.
  - Read: data_o = RAM[idx] as of the cycle entering RESP.
  - Write: RAM[idx] <= latched data on the edge entering RESP; data_o = 0.
  - Next state is IDLE unconditionally. ready_o, err_o and data_o are registered and return to 0 in IDLE.
- Back-to-back requests:
  - cs is only sampled in IDLE.
  - If cs stays high after ready, a new request is accepted on the first IDLE cycle. Minimum request spacing is LATENCY + 2 cycles.
  - The initiator deasserts cs in the cycle after seeing ready_o to avoid a duplicate access.
- Error conditions (checked on the latched address):
  - addr[1:0] != 0, or addr[31:2] >= SIZE.
  - Response: ready_o = 1, err_o = 1, data_o = 0; no RAM write.
  - Timing is identical to a normal access.
- Request inputs changing while in WAIT/RESP are ignored, because only the latched values are used.
- Reset asserted mid-operation aborts the access. A write not yet committed (still in WAIT) must not modify RAM. No ready pulse is produced after rst deasserts.
- Simultaneous read and write do not occur, since there is a single port and a single outstanding request.
- Counter width is 4 bits. LATENCY > 15 is illegal; the implementation flags it with an elaboration-time error.

Test Plan:
- Reset and idle:
  - Assert rst = 0 mid-WAIT of a write to addr 0x08 (data 0xDEADBEEF), release, then read 0x08.
  - Required: outputs 0 during reset, no ready pulse, read returns prior contents, not 0xDEADBEEF.
- Write then read, LATENCY = 2:
  - Write 0x12345678 to 0x04, then read 0x04.
  - Required: ready_o exactly 3 cycles after the cs acceptance edge for each access, err_o = 0, read data_o = 0x12345678.
- LATENCY = 0:
  - Read 0x00 after writing 0xA5A5A5A5.
  - Required: ready_o on the cycle after acceptance, data_o = 0xA5A5A5A5, busy_o high for 1 cycle.
- Errors:
  - Write to 0x02, then write to 0x80 (SIZE = 32).
  - Required: both give ready_o = 1, err_o = 1, data_o = 0.
  - Subsequent reads of 0x00 and 0x7C are unchanged.
- Held cs:
  - Keep cs = 1 with we = 0 and addr 0x10 for 10 cycles, LATENCY = 2.
  - Required: ready pulses at cycles 3 and 7 (spacing 4); no acceptance during WAIT/RESP.
- Input churn:
  - Change addr_i to 0x14 and data_i during WAIT of a write to 0x10 with 0x11111111.
  - Required: RAM[4] = 0x11111111 and RAM[5] is unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM responder with one outstanding request and a cs/we handshake.
// Latency: the response appears LATENCY+1 cycles after acceptance, as a one-cycle registered ready_o pulse.
// Backpressure: cs is sampled only in IDLE, so inputs that change while busy_o is high are ignored.
module data_mem_responder #(
  parameter int SIZE    = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);
  localparam int AW = $clog2(SIZE);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 0..15");
  end
  if (SIZE < 2 || SIZE > 1024 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
    $error("data_mem_responder: SIZE must be a power of two in 2..1024");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q, wdat_q;
  logic          take, enter_resp;
  logic          req_we, req_err, mem_wr;
  logic [31:0]   req_addr, req_dat;
  logic [29:0]   req_widx;
  logic [AW-1:0] req_idx;
  logic [31:0]   mem [SIZE];

  // With zero wait states the access completes on the acceptance edge, so use the live request.
  assign take     = (state_q == S_IDLE) && cs;
  assign req_addr = (state_q == S_IDLE) ? addr_i : addr_q;
  assign req_dat  = (state_q == S_IDLE) ? data_i : wdat_q;
  assign req_we   = (state_q == S_IDLE) ? we     : we_q;
  assign req_widx = req_addr[31:2];
  assign req_idx  = req_widx[AW-1:0];
  assign req_err  = (req_addr[1:0] != 2'b00) || (req_widx >= 30'(SIZE));
  // The RAM is not reset, so its write enable must be held off while rst is asserted.
  assign mem_wr   = enter_resp && req_we && !req_err && rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs) begin
          cnt_d = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdat_q  <= 32'd0;
      data_o  <= 32'd0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      if (take) begin
        we_q   <= we;
        addr_q <= addr_i;
        wdat_q <= data_i;
      end
      ready_o <= enter_resp;
      err_o   <= enter_resp && req_err;
      data_o  <= (enter_resp && !req_we && !req_err) ? mem[req_idx] : 32'd0;
      busy_o  <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[req_idx] <= req_dat;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance, table vectors, corner sequences, and random traffic against an array model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;
  logic        cs2, cs0;
  logic [31:0] dat2, dat0, dat;
  logic        rdy2, rdy0, rdy, err2, err0, err, bsy2, bsy0, bsy;

  int total = 0;
  int bad = 0;
  logic [31:0] model [2][32];

  always #5 clk = ~clk;

  assign cs2 = cs & ~sel;
  assign cs0 = cs & sel;
  assign dat = sel ? dat0 : dat2;
  assign rdy = sel ? rdy0 : rdy2;
  assign err = sel ? err0 : err2;
  assign bsy = sel ? bsy0 : bsy2;

  data_mem_responder #(.SIZE(32), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .we(we), .addr_i(addr_i), .data_i(data_i),
    .data_o(dat2), .ready_o(rdy2), .err_o(err2), .busy_o(bsy2)
  );
  data_mem_responder #(.SIZE(32), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .cs(cs0), .we(we), .addr_i(addr_i), .data_i(data_i),
    .data_o(dat0), .ready_o(rdy0), .err_o(err0), .busy_o(bsy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Access rules: misaligned or beyond 32 words is an error; writes return 0; reads return stored data.
  task automatic model_access(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] ed, output logic ee);
    ee = (a % 4 != 0) || (a / 4 >= 32);
    ed = 32'd0;
    if (!ee) begin
      if (w) model[s][a / 4] = d;
      else   ed = model[s][a / 4];
    end
  endtask

  // Called #1 after a rising edge with the selected DUT idle.
  task automatic do_req(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic re, output int lat, output int bcnt);
    sel = s; cs = 1'b1; we = w; addr_i = a; data_i = d;
    lat = 0; bcnt = 0; rd = 32'd0; re = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bsy) bcnt++;
      if (rdy) begin
        lat = n; rd = dat; re = err;
        break;
      end
    end
    cs = 1'b0;
    @(posedge clk); #1;
    chk("pulse_end", {30'd0, rdy, bsy}, 32'd0);
  endtask

  typedef struct {
    bit          s;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_dat;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd, ed;
    logic        re, ee;
    int          lat, bcnt;
    logic [15:0] seen;
    bit          any_rdy;

    vecs[0]  = '{0, 1, 32'h04, 32'h12345678, 32'h0, 0, 3};
    vecs[1]  = '{0, 0, 32'h04, 32'h0,        32'h12345678, 0, 3};
    vecs[2]  = '{0, 1, 32'h02, 32'hBAD0BAD0, 32'h0, 1, 3};
    vecs[3]  = '{0, 1, 32'h80, 32'hBAD1BAD1, 32'h0, 1, 3};
    vecs[4]  = '{0, 0, 32'h00, 32'h0,        32'hC0DE0000, 0, 3};
    vecs[5]  = '{0, 0, 32'h7C, 32'h0,        32'hC0DE001F, 0, 3};
    vecs[6]  = '{0, 0, 32'h03, 32'h0,        32'h0, 1, 3};
    vecs[7]  = '{0, 0, 32'h100, 32'h0,       32'h0, 1, 3};
    vecs[8]  = '{1, 1, 32'h00, 32'hA5A5A5A5, 32'h0, 0, 1};
    vecs[9]  = '{1, 0, 32'h00, 32'h0,        32'hA5A5A5A5, 0, 1};
    vecs[10] = '{1, 0, 32'h7E, 32'h0,        32'h0, 1, 1};
    vecs[11] = '{1, 0, 32'h7C, 32'h0,        32'hC0DE001F, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_l2", {dat2[29:0], rdy2, bsy2} | {31'd0, err2}, 32'd0);
    chk("reset_outputs_l0", {dat0[29:0], rdy0, bsy0} | {31'd0, err0}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32; i++) begin
        model_access(s[0], 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), ed, ee);
        do_req(s[0], 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), rd, re, lat, bcnt);
      end
    end
    chk("init_lat", 32'(lat), 32'd1);

    for (int v = 0; v < 12; v++) begin
      model_access(vecs[v].s, vecs[v].w, vecs[v].a, vecs[v].d, ed, ee);
      do_req(vecs[v].s, vecs[v].w, vecs[v].a, vecs[v].d, rd, re, lat, bcnt);
      chk($sformatf("vec%0d_data", v), rd, vecs[v].exp_dat);
      chk($sformatf("vec%0d_err", v), {31'd0, re}, {31'd0, vecs[v].exp_err});
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_busy", v), 32'(bcnt), 32'(vecs[v].exp_lat));
    end

    // Reset in the middle of a write's wait states must leave RAM untouched.
    model_access(1'b0, 1'b1, 32'h08, 32'hCAFEF00D, ed, ee);
    do_req(1'b0, 1'b1, 32'h08, 32'hCAFEF00D, rd, re, lat, bcnt);
    sel = 1'b0; cs = 1'b1; we = 1'b1; addr_i = 32'h08; data_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midreset_outputs", dat2 | {30'd0, rdy2, bsy2} | {31'd0, err2}, 32'd0);
    cs = 1'b0;
    any_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst = 1'b1;
      if (rdy2) any_rdy = 1'b1;
    end
    chk("midreset_no_ready", {31'd0, any_rdy}, 32'd0);
    do_req(1'b0, 1'b0, 32'h08, 32'h0, rd, re, lat, bcnt);
    chk("midreset_read", rd, 32'hCAFEF00D);

    // Held cs: a new read is taken on every IDLE cycle.
    sel = 1'b0; cs = 1'b1; we = 1'b0; addr_i = 32'h10; data_i = 32'h0;
    seen = 16'd0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (rdy2) begin
        seen[c] = 1'b1;
        chk($sformatf("held_data_c%0d", c), dat2, model[0][4]);
      end
      if (c == 10) cs = 1'b0;
    end
    chk("held_pulse_cycles", {16'd0, seen}, 32'h0888);

    // Changing the request inputs during WAIT must not affect the latched write.
    sel = 1'b0; cs = 1'b1; we = 1'b1; addr_i = 32'h10; data_i = 32'h11111111;
    @(posedge clk); #1;
    addr_i = 32'h14; data_i = 32'h22222222; we = 1'b0;
    lat = 0;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
      if (rdy2) begin
        lat = n;
        break;
      end
    end
    cs = 1'b0;
    chk("churn_lat", 32'(lat), 32'd3);
    model_access(1'b0, 1'b1, 32'h10, 32'h11111111, ed, ee);
    @(posedge clk); #1;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, re, lat, bcnt);
    chk("churn_word4", rd, 32'h11111111);
    model_access(1'b0, 1'b0, 32'h14, 32'h0, ed, ee);
    do_req(1'b0, 1'b0, 32'h14, 32'h0, rd, re, lat, bcnt);
    chk("churn_word5", rd, ed);

    for (int t = 0; t < 80; t++) begin
      bit          s, w;
      logic [31:0] a, d;
      int          r;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'($urandom_range(32, 200) * 4);
      else if (r == 2) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else             a = 32'($urandom_range(0, 31) * 4);
      model_access(s, w, a, d, ed, ee);
      do_req(s, w, a, d, rd, re, lat, bcnt);
      chk($sformatf("rnd%0d_data", t), rd, ed);
      chk($sformatf("rnd%0d_err", t), {31'd0, re}, {31'd0, ee});
      chk($sformatf("rnd%0d_lat", t), 32'(lat), s ? 32'd1 : 32'd3);
    end

    for (int i = 0; i < 32; i++) begin
      do_req(1'b0, 1'b0, 32'(i * 4), 32'h0, rd, re, lat, bcnt);
      chk($sformatf("final_l2_w%0d", i), rd, model[0][i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
